// File: rtl/synth_cfg_tx_if.sv
// synth_cfg_tx_if: command push port and synth config bus of synth_cfg_tx
interface synth_cfg_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic [1:0]  in_be;
  logic [7:0]  cfg_data;
  logic [2:0]  cfg_addr;
  logic        cfg_addr0;
  logic        cfg_strobe;
  logic        busy;
  modport master (
    output in_valid, in_addr, in_data, in_be,
    input  in_ready, cfg_data, cfg_addr, cfg_addr0, cfg_strobe, busy
  );
  modport slave (
    input  in_valid, in_addr, in_data, in_be,
    output in_ready, cfg_data, cfg_addr, cfg_addr0, cfg_strobe, busy
  );
endinterface

// File: rtl/synth_cfg_tx.sv
// synth_cfg_tx: queues 16-bit config writes and sends them bytewise on a strobed 8-bit bus.
// Define SYNTH_CFG_TX_SHADOW_EN to skip bytes that match the last value already sent.
module synth_cfg_tx #(
  parameter int STROBE_HIGH_CYCLES = 4,
  parameter int STROBE_LOW_CYCLES  = 4,
  parameter int FIFO_LOG2_DEPTH    = 2
) (
  input logic clk,
  input logic reset,
  synth_cfg_tx_if.slave bus
);
  localparam int D = 1 << FIFO_LOG2_DEPTH;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW} state_t;
  state_t state;
  logic [20:0] mem [D];
  logic [FIFO_LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2_DEPTH:0] count;
  logic full, empty, push, pop;
  logic [2:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0] cmd_be, eff_be;
  logic hi_pending;
  logic [3:0] cnt;
  logic [7:0] cfg_data;
  logic [2:0] cfg_addr;
  logic cfg_addr0, cfg_strobe;
  assign full = count == (FIFO_LOG2_DEPTH+1)'(D);
  assign empty = count == '0;
  assign push = bus.in_valid && !full;
  assign pop = state == IDLE && !empty;
  assign bus.in_ready = !full;
  assign bus.busy = state != IDLE || !empty;
  assign bus.cfg_data = cfg_data;
  assign bus.cfg_addr = cfg_addr;
  assign bus.cfg_addr0 = cfg_addr0;
  assign bus.cfg_strobe = cfg_strobe;
`ifdef SYNTH_CFG_TX_SHADOW_EN
  logic [15:0] shadow [8];
  assign eff_be = {cmd_be[1] && cmd_data[15:8] != shadow[cmd_addr][15:8],
                   cmd_be[0] && cmd_data[7:0] != shadow[cmd_addr][7:0]};
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    else if (state == SETUP && cfg_addr0)
      shadow[cfg_addr][15:8] <= cfg_data;
    else if (state == SETUP)
      shadow[cfg_addr][7:0] <= cfg_data;
`else
  assign eff_be = cmd_be;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.in_addr, bus.in_data, bus.in_be};
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_LOG2_DEPTH'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_LOG2_DEPTH'(1);
      count <= count + (FIFO_LOG2_DEPTH+1)'(push) - (FIFO_LOG2_DEPTH+1)'(pop);
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_be <= '0;
      hi_pending <= 1'b0;
      cnt <= '0;
      cfg_data <= '0;
      cfg_addr <= '0;
      cfg_addr0 <= 1'b0;
      cfg_strobe <= 1'b0;
    end else
      case (state)
        IDLE:
          if (!empty) begin
            {cmd_addr, cmd_data, cmd_be} <= mem[rd_ptr];
            state <= LOAD;
          end
        LOAD:
          if (eff_be == 2'b00) state <= IDLE;
          else begin
            cfg_addr <= cmd_addr;
            cfg_addr0 <= !eff_be[0];
            cfg_data <= eff_be[0] ? cmd_data[7:0] : cmd_data[15:8];
            hi_pending <= &eff_be;
            state <= SETUP;
          end
        SETUP: begin
          cfg_strobe <= 1'b1;
          cnt <= 4'(STROBE_HIGH_CYCLES - 1);
          state <= HIGH;
        end
        HIGH:
          if (cnt != '0) cnt <= cnt - 4'd1;
          else begin
            cfg_strobe <= 1'b0;
            cnt <= 4'(STROBE_LOW_CYCLES - 1);
            state <= LOW;
          end
        LOW:
          if (cnt != '0) cnt <= cnt - 4'd1;
          else if (hi_pending) begin
            cfg_addr0 <= 1'b1;
            cfg_data <= cmd_data[15:8];
            hi_pending <= 1'b0;
            state <= SETUP;
          end else state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_synth_cfg_tx.sv
// tb_synth_cfg_tx: table vectors, timing sequences and a randomized run against a byte-level model.
module tb_synth_cfg_tx;
  localparam int H = 4;
  localparam int L = 4;
  typedef struct packed {logic [2:0] a; logic a0; logic [7:0] d;} byte_t;
  typedef struct {logic [2:0] a; logic [15:0] d; logic [1:0] be; int n; byte_t b0; byte_t b1;} vec_t;
  logic clk = 0, reset = 1;
  int checks = 0, failures = 0;
  byte_t cap[$], exp_q[$], held;
  logic [15:0] rx [8];
  logic [15:0] mrx [8];
  logic prev = 0;
  int hi_run = 0, lo_run = -1, max_gap = 0;
  vec_t tbl [6];
  synth_cfg_tx_if bus();
  synth_cfg_tx #(.STROBE_HIGH_CYCLES(H), .STROBE_LOW_CYCLES(L), .FIFO_LOG2_DEPTH(2))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (reset) begin
      prev = 0;
      hi_run = 0;
      lo_run = -1;
    end else begin
      if (bus.cfg_strobe && !prev) begin
        held = {bus.cfg_addr, bus.cfg_addr0, bus.cfg_data};
        cap.push_back(held);
        if (bus.cfg_addr0) rx[bus.cfg_addr][15:8] = bus.cfg_data;
        else rx[bus.cfg_addr][7:0] = bus.cfg_data;
        if (lo_run >= 0) begin
          chk("low_gap_min", lo_run >= L + 1, 1);
          if (lo_run > max_gap) max_gap = lo_run;
        end
        hi_run = 1;
      end else if (bus.cfg_strobe) begin
        hi_run++;
        chk("stable_high", {bus.cfg_addr, bus.cfg_addr0, bus.cfg_data}, held);
      end else if (prev) begin
        chk("high_len", hi_run, H);
        lo_run = 1;
        chk("stable_low", {bus.cfg_addr, bus.cfg_addr0, bus.cfg_data}, held);
      end else if (lo_run >= 0) begin
        lo_run++;
        if (lo_run <= L) chk("stable_low", {bus.cfg_addr, bus.cfg_addr0, bus.cfg_data}, held);
      end
      prev = bus.cfg_strobe;
    end
  task automatic do_reset();
    reset = 1;
    bus.in_valid = 0;
    tick(1);
    reset = 0;
    cap.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rx[i] = '0;
      mrx[i] = '0;
    end
  endtask
  task automatic model_cmd(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [1:0] e;
    e = be;
`ifdef SYNTH_CFG_TX_SHADOW_EN
    if (d[7:0] == mrx[a][7:0]) e[0] = 0;
    if (d[15:8] == mrx[a][15:8]) e[1] = 0;
`endif
    if (e[0]) begin
      exp_q.push_back({a, 1'b0, d[7:0]});
      mrx[a][7:0] = d[7:0];
    end
    if (e[1]) begin
      exp_q.push_back({a, 1'b1, d[15:8]});
      mrx[a][15:8] = d[15:8];
    end
  endtask
  task automatic push(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    bit ok = 0;
    bus.in_addr = a;
    bus.in_data = d;
    bus.in_be = be;
    bus.in_valid = 1;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (bus.in_ready) ok = 1;
      tick(1);
    end
    bus.in_valid = 0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++)
      if (!bus.busy) ok = 1;
      else tick(1);
    if (!ok) chk("drain_timeout", 0, 1);
    tick(2);
  endtask
  task automatic cmp_model(input string name);
    chk({name, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) chk({name, "_byte"}, cap[i], exp_q[i]);
    for (int i = 0; i < 8; i++) chk({name, "_rx"}, rx[i], mrx[i]);
  endtask
  initial begin
    tbl[0] = '{3'd2, 16'h1234, 2'b11, 2, {3'd2, 1'b0, 8'h34}, {3'd2, 1'b1, 8'h12}};
    tbl[1] = '{3'd7, 16'hAB00, 2'b10, 1, {3'd7, 1'b1, 8'hAB}, '0};
    tbl[2] = '{3'd5, 16'h5A5A, 2'b00, 0, '0, '0};
    tbl[3] = '{3'd0, 16'hFFEE, 2'b01, 1, {3'd0, 1'b0, 8'hEE}, '0};
`ifdef SYNTH_CFG_TX_SHADOW_EN
    tbl[4] = '{3'd1, 16'h00FF, 2'b11, 1, {3'd1, 1'b0, 8'hFF}, '0};
`else
    tbl[4] = '{3'd1, 16'h00FF, 2'b11, 2, {3'd1, 1'b0, 8'hFF}, {3'd1, 1'b1, 8'h00}};
`endif
    tbl[5] = '{3'd3, 16'h8001, 2'b11, 2, {3'd3, 1'b0, 8'h01}, {3'd3, 1'b1, 8'h80}};
    bus.in_valid = 0;
    bus.in_addr = 0;
    bus.in_data = 0;
    bus.in_be = 0;
    tick(2);
    do_reset();
    chk("rst_strobe", bus.cfg_strobe, 0);
    chk("rst_data", bus.cfg_data, 0);
    chk("rst_addr", bus.cfg_addr, 0);
    chk("rst_addr0", bus.cfg_addr0, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.in_ready, 1);
    // latency sequence: accept at E0, then observe 1 cycle after each edge
    bus.in_addr = 2; bus.in_data = 16'h1234; bus.in_be = 2'b11; bus.in_valid = 1;
    tick(1);
    bus.in_valid = 0;
    chk("lat_busy_e0", bus.busy, 1);
    tick(1);
    chk("lat_strobe_e1", bus.cfg_strobe, 0);
    tick(1);
    chk("lat_setup_e2", {bus.cfg_strobe, bus.cfg_addr, bus.cfg_addr0, bus.cfg_data}, {1'b0, 3'd2, 1'b0, 8'h34});
    tick(1);
    chk("lat_strobe_e3", bus.cfg_strobe, 1);
    tick(H + L - 1);
    chk("lat_low_end", {bus.cfg_strobe, bus.cfg_addr0, bus.cfg_data}, {1'b0, 1'b0, 8'h34});
    tick(1);
    chk("lat_setup_hi", {bus.cfg_strobe, bus.cfg_addr, bus.cfg_addr0, bus.cfg_data}, {1'b0, 3'd2, 1'b1, 8'h12});
    tick(1);
    chk("lat_strobe_hi", bus.cfg_strobe, 1);
    tick(H + L - 1);
    chk("lat_busy_last", bus.busy, 1);
    tick(1);
    chk("lat_busy_end", bus.busy, 0);
    chk("lat_bytes", cap.size(), 2);
    // discarded be=00 command: busy through IDLE and LOAD only
    do_reset();
    bus.in_addr = 5; bus.in_data = 16'h5A5A; bus.in_be = 2'b00; bus.in_valid = 1;
    tick(1);
    bus.in_valid = 0;
    chk("be0_busy0", bus.busy, 1);
    tick(1);
    chk("be0_busy1", bus.busy, 1);
    tick(1);
    chk("be0_busy2", bus.busy, 0);
    tick(20);
    chk("be0_nobytes", cap.size(), 0);
    for (int v = 0; v < 6; v++) begin
      do_reset();
      push(tbl[v].a, tbl[v].d, tbl[v].be);
      drain();
      chk("tbl_count", cap.size(), tbl[v].n);
      if (cap.size() > 0) chk("tbl_b0", cap[0], tbl[v].b0);
      if (cap.size() > 1) chk("tbl_b1", cap[1], tbl[v].b1);
    end
    // repeated command: shadow suppresses everything the second time
    do_reset();
    push(3'd1, 16'h00FF, 2'b11);
    drain();
    push(3'd1, 16'h00FF, 2'b11);
    drain();
`ifdef SYNTH_CFG_TX_SHADOW_EN
    chk("repeat_count", cap.size(), 1);
`else
    chk("repeat_count", cap.size(), 4);
`endif
    // back-to-back fill: full after 5 accepts since one entry is popped at once
    do_reset();
    max_gap = 0;
    for (int i = 0; i < 6; i++) begin
      push(3'(i), {8'(8'h11 * (i + 1)), 8'(8'h21 + i)}, 2'b11);
      model_cmd(3'(i), {8'(8'h11 * (i + 1)), 8'(8'h21 + i)}, 2'b11);
      if (i == 3) chk("b2b_ready_4", bus.in_ready, 1);
      if (i == 4) chk("b2b_ready_5", bus.in_ready, 0);
    end
    drain();
    cmp_model("b2b");
    chk("b2b_max_gap", max_gap, L + 3);
    // randomized traffic against the byte-level model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] a;
      logic [15:0] d;
      logic [1:0] be;
      a = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0) ? mrx[a] : 16'($urandom);
      be = 2'($urandom_range(0, 3));
      push(a, d, be);
      model_cmd(a, d, be);
      tick($urandom_range(0, 4));
    end
    drain();
    cmp_model("rand");
    // reset in the second HIGH cycle with two entries queued
    do_reset();
    push(3'd4, 16'hC3A5, 2'b11);
    push(3'd5, 16'h7E81, 2'b11);
    push(3'd6, 16'h1F2E, 2'b01);
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++)
        if (bus.cfg_strobe) ok = 1;
        else tick(1);
      if (!ok) chk("abort_wait", 0, 1);
    end
    tick(1);
    chk("abort_high2", bus.cfg_strobe, 1);
    reset = 1;
    tick(1);
    reset = 0;
    chk("abort_strobe", bus.cfg_strobe, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.in_ready, 1);
    cap.delete();
    tick(80);
    chk("abort_nobytes", cap.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
